// File: rtl/temp_reg_pkg.sv
// temp_reg shared types and constants.
// Default data width, word type and reset value for the holding register.
package temp_reg_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t RESET_VAL = '0;

endpackage

// File: rtl/temp_reg.sv
// temp_reg: single-word holding register for the microcode datapath.
// Optional macro TEMP_REG_ASSERT_EN compiles in behavioural assertions.
module temp_reg #(
  parameter int WIDTH = temp_reg_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_val,
  input  logic             wr_en,
  output logic [WIDTH-1:0] val
);

  import temp_reg_pkg::*;

  // Capture wr_val on enabled edges; async reset clears the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      val <= WIDTH'(RESET_VAL);
    else if (wr_en)
      val <= wr_val;
  end

`ifdef TEMP_REG_ASSERT_EN
  // A reset pulse landing between two edges voids the write/hold
  // expectation for the edge that follows it.
  logic rst_seen;

  // Remember any reset activity since the previous clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rst_seen <= 1'b1;
    else
      rst_seen <= 1'b0;
  end

  a_reset_zero: assert property (
    @(negedge clk) reset |-> (val == WIDTH'(RESET_VAL))
  ) else $error("%m: val not zero during reset");

  a_write: assert property (
    @(posedge clk) disable iff (reset)
    wr_en |=> (rst_seen || val == $past(wr_val))
  ) else $error("%m: val does not match written value");

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    !wr_en |=> (rst_seen || val == $past(val))
  ) else $error("%m: val changed without write enable");

  a_wr_en_known: assert property (
    @(posedge clk) !reset |-> !$isunknown(wr_en)
  ) else $error("%m: wr_en is X/Z out of reset");
`endif

endmodule

// File: tb/tb_temp_reg.sv
// Self-checking bench for temp_reg.
// Scoreboard queue of expected values, compared one cycle after drive.
module tb_temp_reg;

  logic        clk;
  logic        reset;
  logic [15:0] wr_val;
  logic        wr_en;
  logic [15:0] val;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model;
  logic [15:0] exp_q[$];

  temp_reg #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_val (wr_val),
    .wr_en  (wr_en),
    .val    (val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle at negedge, push the model's post-edge value,
  // then pop and compare just after the rising edge.
  task automatic cyc(input logic we,
                     input logic [15:0] v,
                     input string tag);
    logic [15:0] e;
    @(negedge clk);
    wr_en  = we;
    wr_val = v;
    #1;
    chk({tag, "_pre"}, val, model);
    if (we) model = v;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, val, 16'hxxxx);
    end else begin
      e = exp_q.pop_front();
      chk(tag, val, e);
    end
  endtask

  initial begin
    logic [15:0] pats [6];
    pats = '{16'h0000, 16'hFFFF, 16'h0001,
             16'h8000, 16'hAAAA, 16'h5555};

    reset  = 1'b1;
    wr_en  = 1'b0;
    wr_val = 16'h0000;
    model  = 16'h0000;
    #1;
    chk("reset_async", val, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", val, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 16'hDEAD, "idle0");
    cyc(1'b0, 16'hBEEF, "idle1");

    cyc(1'b1, 16'h1234, "wr1234");
    cyc(1'b1, 16'h5678, "wr5678");
    cyc(1'b0, 16'hFFFF, "hold0");
    cyc(1'b0, 16'hFFFF, "hold1");

    for (int i = 0; i < 5; i++)
      cyc(1'b1, 16'h1000 + 16'(i), "burst");
    cyc(1'b0, 16'h2222, "burst_end");

    cyc(1'b1, 16'hABCD, "wrABCD");
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset", val, 16'h0000);
    model = 16'h0000;
    #1;
    reset = 1'b0;
    #1;
    chk("post_release", val, 16'h0000);
    cyc(1'b0, 16'h7777, "rel_idle0");
    cyc(1'b0, 16'h7777, "rel_idle1");
    cyc(1'b1, 16'h3C3C, "rel_write");

    cyc(1'b1, 16'h9876, "wr9876");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 16'(i * 16'h1111), "retain");

    foreach (pats[i])
      cyc(1'b1, pats[i], "pattern");

    for (int i = 0; i < 16; i++)
      cyc(1'b1, 16'(1) << i, "walk1");

    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), "rand");

    if (exp_q.size() != 0)
      chk("queue_drain", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
